// File: rtl/fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb_pkg
//  Description : Shared definitions for the FIFO write-side arbiter: lock FSM
//                state encoding, a constant clog2 helper, and the default
//                NREQ/DSIZE/BURST values shared with the FIFO top.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_arb_pkg;

    localparam int C_NREQ_DEF  = 4;
    localparam int C_DSIZE_DEF = 8;
    localparam int C_BURST_DEF = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Smallest r with 2**r >= value; usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb_if
//  Description : Requester/FIFO-write bundle seen by the write arbiter.
//  Ports       : req_valid/req_data (requesters -> arbiter), req_ready
//                (arbiter -> requesters), wfull (FIFO -> arbiter),
//                wr/wdata (arbiter -> FIFO), owner/busy (status).
//                modport master : arbiter side
//                modport slave  : requester/FIFO side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_arb_if
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ  = C_NREQ_DEF,
    parameter int DSIZE = C_DSIZE_DEF
) ();

    localparam int c_ow = clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  wr;
    logic [DSIZE-1:0]      wdata;
    logic [c_ow-1:0]       owner;
    logic                  busy;

    modport master (
        input  req_valid, req_data, wfull,
        output req_ready, wr, wdata, owner, busy
    );

    modport slave (
        output req_valid, req_data, wfull,
        input  req_ready, wr, wdata, owner, busy
    );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb_rr_pick
//  Description : Combinational round-robin picker. Scans last+1, last+2, ...
//                modulo NREQ (last itself is scanned last) and returns the
//                first requesting index.
//  Ports       : req     in  NREQ  request vector
//                last    in  IW    index of the previous winner
//                gnt_idx out IW    chosen index (0 when gnt_any=0)
//                gnt_any out 1     any request present
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb_rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ = C_NREQ_DEF,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = last;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap keeps non-power-of-2 NREQ inside 0..NREQ-1.
            w_idx = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
            if (!gnt_any && req[w_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arb
//  Description : Shares the FIFO write port among NREQ producers using
//                round-robin arbitration with burst locking (up to BURST
//                consecutive beats per owner) and a one-entry output stage.
//                No write is issued while wfull is high.
//  Ports       : wclk    in   write clock
//                wrst_n  in   asynchronous active-low reset
//                bus     master modport of fifo_wr_arb_if
//                        (req_valid/req_data/wfull in,
//                         req_ready/wr/wdata/owner/busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NREQ  = C_NREQ_DEF,
    parameter int DSIZE = C_DSIZE_DEF,
    parameter int BURST = C_BURST_DEF
) (
    input  logic          wclk,
    input  logic          wrst_n,
    fifo_wr_arb_if.master bus
);

    localparam int            c_ow        = clog2(NREQ);
    localparam int            c_cw        = clog2(BURST + 1);
    localparam logic [c_ow-1:0] c_owner_rst = c_ow'(NREQ - 1);
    localparam logic [c_cw-1:0] c_burst     = c_cw'(BURST);

    arb_state_t        r_state;
    logic [c_ow-1:0]   r_owner;
    logic [c_cw-1:0]   r_beat_cnt;
    logic              r_out_valid;
    logic [DSIZE-1:0]  r_out_data;

    logic              w_wr;
    logic              w_load;
    logic              w_keep;
    logic              w_pick_any;
    logic [c_ow-1:0]   w_pick_idx;
    logic              w_gnt_any;
    logic [c_ow-1:0]   w_gnt_idx;
    logic              w_xfer;
    logic              w_same;
    logic [c_cw-1:0]   w_cnt_next;
    logic [DSIZE-1:0]  w_gnt_data;

    // Write and refill can happen in the same cycle, giving 1 beat/cycle.
    assign w_wr   = r_out_valid & ~bus.wfull;
    assign w_load = ~r_out_valid | w_wr;

    // The locked owner keeps the grant while it is valid and under budget.
    assign w_keep = (r_state == ST_LOCK) && bus.req_valid[r_owner] &&
                    (r_beat_cnt < c_burst);

    fifo_wr_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (c_ow)
    ) u_rr_pick (
        .req     (bus.req_valid),
        .last    (r_owner),
        .gnt_idx (w_pick_idx),
        .gnt_any (w_pick_any)
    );

    assign w_gnt_any  = w_keep | w_pick_any;
    assign w_gnt_idx  = w_keep ? r_owner : w_pick_idx;
    // No handshake is offered while reset is held.
    assign w_xfer     = w_load & w_gnt_any & wrst_n;
    assign w_same     = (r_state == ST_LOCK) && (w_gnt_idx == r_owner);
    assign w_cnt_next = w_same ? r_beat_cnt + c_cw'(1) : c_cw'(1);
    assign w_gnt_data = bus.req_data[w_gnt_idx*DSIZE +: DSIZE];

    assign bus.req_ready = w_xfer ? (NREQ'(1) << w_gnt_idx) : '0;
    assign bus.wr        = w_wr;
    assign bus.wdata     = r_out_data;
    assign bus.busy      = r_out_valid;
    assign bus.owner     = r_owner;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state     <= ST_IDLE;
            r_owner     <= c_owner_rst;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_xfer) begin
            r_out_data  <= w_gnt_data;
            r_out_valid <= 1'b1;
            r_owner     <= w_gnt_idx;
            r_beat_cnt  <= w_cnt_next;
            // Owner stays put on release so owner+1 gets next priority.
            r_state     <= (w_cnt_next == c_burst) ? ST_IDLE : ST_LOCK;
        end else if (w_load) begin
            // Stage free but nobody granted: in LOCK this means the owner
            // dropped valid, so the lock is released.
            if (w_wr) begin
                r_out_valid <= 1'b0;
            end
            r_state <= ST_IDLE;
        end
        // load=0 (held beat blocked by wfull): everything frozen.
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arb
//  Description : Self-checking bench for fifo_wr_arb (NREQ=4, DSIZE=8,
//                BURST=4): vector table, directed multi-cycle sequences and
//                randomized traffic compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;
    import fifo_wr_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    fifo_wr_arb #(
        .NREQ  (NREQ),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    int n_checks;
    int n_errors;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_held[$];   // beat waiting in the output stage (0 or 1)
    int         m_owner;     // last requester that supplied a beat
    int         m_streak;    // beats in the current lock, 0 = no lock

    task automatic model_reset();
        m_held.delete();
        m_owner  = NREQ - 1;
        m_streak = 0;
    endtask

    function automatic void model_eval(output logic [NREQ-1:0] e_ready, output logic e_wr,
                                       output logic e_take, output int e_g);
        e_wr   = wrst_n && (m_held.size() != 0) && !bus.wfull;
        e_take = wrst_n && ((m_held.size() == 0) || e_wr);
        e_g    = -1;
        if (e_take) begin
            if (m_streak > 0 && bus.req_valid[m_owner]) begin
                e_g = m_owner;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (e_g < 0 && bus.req_valid[(m_owner + k) % NREQ]) e_g = (m_owner + k) % NREQ;
                end
            end
        end
        e_ready = (e_g >= 0) ? NREQ'(1 << e_g) : '0;
    endfunction

    // ---------------- producers ----------------
    logic [7:0] pbuf [NREQ][64];
    int         ph[NREQ];
    int         pt[NREQ];
    bit         prod_mode;
    int         n_acc;
    logic [7:0] wlog[$];
    int         wcyc[$];

    task automatic prod_clear();
        for (int i = 0; i < NREQ; i++) begin
            ph[i] = 0;
            pt[i] = 0;
        end
    endtask

    task automatic push(input int i, input logic [7:0] v);
        pbuf[i][pt[i] % 64] = v;
        pt[i]++;
    endtask

    task automatic drive_prod();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (pt[i] != ph[i]);
            bus.req_data[i*DSIZE +: DSIZE] = (pt[i] != ph[i]) ? pbuf[i][ph[i] % 64] : 8'h00;
        end
    endtask

    // Compare every DUT output with the model, away from the active edge.
    task automatic tick_check();
        logic [NREQ-1:0] e_ready;
        logic            e_wr;
        logic            e_take;
        int              e_g;
        @(negedge wclk);
        model_eval(e_ready, e_wr, e_take, e_g);
        chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
        chk("wr", 32'(bus.wr), 32'(e_wr));
        chk("busy", 32'(bus.busy), 32'(m_held.size() != 0));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        if (m_held.size() != 0) chk("wdata", 32'(bus.wdata), 32'(m_held[0]));
    endtask

    task automatic tick_edge();
        logic [NREQ-1:0] e_ready;
        logic            e_wr;
        logic            e_take;
        int              e_g;
        @(posedge wclk);
        cyc++;
        if (bus.wr) begin
            wlog.push_back(bus.wdata);
            wcyc.push_back(cyc);
        end
        model_eval(e_ready, e_wr, e_take, e_g);
        if (e_wr) void'(m_held.pop_front());
        if (e_take && m_streak > 0 && !bus.req_valid[m_owner]) m_streak = 0;
        if (e_g >= 0) begin
            m_held.push_back(bus.req_data[e_g*DSIZE +: DSIZE]);
            if (m_streak > 0 && e_g == m_owner) begin
                m_streak++;
            end else begin
                m_owner  = e_g;
                m_streak = 1;
            end
            if (m_streak == BURST) m_streak = 0;
            if (prod_mode) begin
                ph[e_g]++;
                n_acc++;
            end
        end
        #1;
        if (prod_mode) drive_prod();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic [3:0] ready;
        logic       wr;
        logic [7:0] wdata;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t tbl[13];

    initial begin
        automatic logic [7:0] hold_v = 8'h00;
        automatic int         b      = 0;
        automatic bit         drained;

        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        n_acc     = 0;
        prod_mode = 1'b0;
        model_reset();
        prod_clear();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.wfull     = 1'b0;

        tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd3};
        tbl[1]  = '{4'b0010, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b0, 2'd3};
        tbl[2]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1};
        tbl[3]  = '{4'b1000, 1'b0, 4'b1000, 1'b1, 8'hA1, 1'b1, 2'd1};
        tbl[4]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 1'b1, 2'd3};
        tbl[5]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 1'b1, 2'd3};
        tbl[6]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hA3, 1'b1, 2'd3};
        tbl[7]  = '{4'b1001, 1'b0, 4'b0001, 1'b1, 8'hA3, 1'b1, 2'd3};
        tbl[8]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'hA0, 1'b1, 2'd0};
        tbl[9]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 8'hA0, 1'b1, 2'd0};
        tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA0, 1'b1, 2'd0};
        tbl[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA0, 1'b1, 2'd0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

        // ---- reset, then 10 idle cycles ----
        repeat (2) begin
            tick_check();
            tick_edge();
        end
        wrst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick_check();
            chk("idle_owner", 32'(bus.owner), 32'd3);
            chk("idle_wr", 32'(bus.wr), 32'd0);
            tick_edge();
        end

        // ---- table: lock drop to 3, burst end to 0, wfull freeze ----
        bus.req_data = 32'hA3A2A1A0;
        for (int r = 0; r < 13; r++) begin
            bus.req_valid = tbl[r].valid;
            bus.wfull     = tbl[r].full;
            tick_check();
            chk($sformatf("tbl%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
            chk($sformatf("tbl%0d_wr", r), 32'(bus.wr), 32'(tbl[r].wr));
            chk($sformatf("tbl%0d_busy", r), 32'(bus.busy), 32'(tbl[r].busy));
            chk($sformatf("tbl%0d_owner", r), 32'(bus.owner), 32'(tbl[r].owner));
            if (tbl[r].busy) chk($sformatf("tbl%0d_wdata", r), 32'(bus.wdata), 32'(tbl[r].wdata));
            tick_edge();
        end

        // ---- requester 2 streams 0x10..0x17 back-to-back ----
        bus.wfull = 1'b0;
        prod_mode = 1'b1;
        wlog.delete();
        wcyc.delete();
        for (int n = 0; n < 8; n++) push(2, 8'(8'h10 + n));
        drive_prod();
        for (int t = 0; t < 40 && wlog.size() < 8; t++) begin
            tick_check();
            tick_edge();
        end
        chk("stream_count", 32'(wlog.size()), 32'd8);
        for (int n = 0; n < wlog.size() && n < 8; n++) begin
            chk($sformatf("stream_data%0d", n), 32'(wlog[n]), 32'(8'h10 + n));
            if (n > 0) chk($sformatf("stream_gap%0d", n), 32'(wcyc[n] - wcyc[n-1]), 32'd1);
        end

        // ---- wfull held for 5 cycles mid-stream on requester 1 ----
        wlog.delete();
        for (int n = 0; n < 12; n++) push(1, 8'(8'h40 + n));
        drive_prod();
        repeat (4) begin
            tick_check();
            tick_edge();
        end
        bus.wfull = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick_check();
            if (t == 0) hold_v = bus.wdata;
            chk("full_wr", 32'(bus.wr), 32'd0);
            chk("full_ready", 32'(bus.req_ready), 32'd0);
            chk("full_busy", 32'(bus.busy), 32'd1);
            chk("full_hold", 32'(bus.wdata), 32'(hold_v));
            tick_edge();
        end
        bus.wfull = 1'b0;
        for (int t = 0; t < 60 && wlog.size() < 12; t++) begin
            tick_check();
            tick_edge();
        end
        chk("full_count", 32'(wlog.size()), 32'd12);
        for (int n = 0; n < wlog.size() && n < 12; n++)
            chk($sformatf("full_data%0d", n), 32'(wlog[n]), 32'(8'h40 + n));

        // ---- reset while busy in LOCK, then all four valid ----
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(i*16 + k));
        drive_prod();
        repeat (6) begin
            tick_check();
            tick_edge();
        end
        #2;
        wrst_n = 1'b0;
        #1;
        chk("rst_wr", 32'(bus.wr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd3);
        model_reset();
        prod_clear();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push(i, 8'(i*16 + k));
        drive_prod();
        wlog.delete();
        tick_check();
        tick_edge();
        wrst_n = 1'b1;
        for (int t = 0; t < 100 && wlog.size() < 32; t++) begin
            tick_check();
            tick_edge();
        end
        chk("rr_count", 32'(wlog.size()), 32'd32);
        for (int n = 0; n < wlog.size() && n < 32; n++) begin
            b = n / BURST;
            chk($sformatf("rr_beat%0d", n), 32'(wlog[n]),
                32'(((b % NREQ) * 16) + (b / NREQ) * BURST + (n % BURST)));
        end

        // ---- randomized traffic against the model ----
        wlog.delete();
        n_acc = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NREQ; i++)
                if ((pt[i] - ph[i]) < 4 && $urandom_range(0, 2) == 0) push(i, 8'($urandom));
            bus.wfull = ($urandom_range(0, 4) == 0);
            drive_prod();
            tick_check();
            tick_edge();
        end
        bus.wfull = 1'b0;
        drained = 1'b0;
        for (int t = 0; t < 200 && !drained; t++) begin
            tick_check();
            tick_edge();
            drained = 1'b1;
            for (int i = 0; i < NREQ; i++) if (pt[i] != ph[i]) drained = 1'b0;
            if (m_held.size() != 0) drained = 1'b0;
        end
        chk("rand_drained", 32'(drained), 32'd1);
        chk("rand_total", 32'(wlog.size()), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
